// File: rtl/c2_channel_router_pkg.sv
// Shared types and default constants for the C2 channel router.
package c2_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACK,
      S_GRANT
   } c2_state_t;

   localparam logic [7:0] ACK_DEFAULT = 8'hA5;
   localparam logic [7:0] NAK_DEFAULT = 8'hEE;

   localparam logic [7:0] CMD_DEBUG  = 8'h44;
   localparam logic [7:0] CMD_LOAD_I = 8'h4C;
   localparam logic [7:0] CMD_UPLOAD = 8'h55;
   localparam logic [7:0] CMD_RUN    = 8'h52;

   // Channel i owns byte [8i+7:8i], so channel 0 sits in the low byte.
   localparam logic [31:0] CMD_CODES_DEFAULT = {CMD_RUN, CMD_UPLOAD, CMD_LOAD_I, CMD_DEBUG};

endpackage

// File: rtl/c2_channel_router_if.sv
// UART and functional-unit signal bundle for c2_channel_router.
interface c2_channel_router_if #(
   parameter int unsigned NUM_CH = 4
);
   logic [7:0]          rx_data_i;
   logic                rx_ready_i;
   logic [7:0]          tx_data_o;
   logic                tx_start_o;
   logic                tx_done_i;
   logic [NUM_CH-1:0]   ch_grant_o;
   logic [NUM_CH-1:0]   ch_rx_valid_o;
   logic [7:0]          ch_rx_data_o;
   logic [NUM_CH-1:0]   ch_done_i;
   logic [NUM_CH-1:0]   ch_tx_valid_i;
   logic [NUM_CH*8-1:0] ch_tx_data_i;
   logic [NUM_CH-1:0]   ch_tx_ready_o;
   logic                soft_reset_o;
   logic                waiting_o;
   logic                busy_o;

   modport master (
      output rx_data_i, rx_ready_i, tx_done_i, ch_done_i, ch_tx_valid_i, ch_tx_data_i,
      input  tx_data_o, tx_start_o, ch_grant_o, ch_rx_valid_o, ch_rx_data_o,
             ch_tx_ready_o, soft_reset_o, waiting_o, busy_o
   );

   modport slave (
      input  rx_data_i, rx_ready_i, tx_done_i, ch_done_i, ch_tx_valid_i, ch_tx_data_i,
      output tx_data_o, tx_start_o, ch_grant_o, ch_rx_valid_o, ch_rx_data_o,
             ch_tx_ready_o, soft_reset_o, waiting_o, busy_o
   );
endinterface

// File: rtl/c2_channel_router_tx_fifo.sv
// Synchronous byte FIFO with extra-bit pointers; push and pop may coincide when full.
module c2_tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/c2_channel_router.sv
// Command-decoding channel router: grants one unit, gates RX, merges TX round-robin.
// Optional inactivity watchdog enabled by defining C2_ROUTER_TIMEOUT_EN.
module c2_channel_router
   import c2_pkg::*;
#(
   parameter int unsigned         NUM_CH         = 4,
   parameter logic [NUM_CH*8-1:0] CMD_CODES      = CMD_CODES_DEFAULT,
   parameter int unsigned         FIFO_DEPTH     = 8,
   parameter logic [7:0]          ACK_BYTE       = ACK_DEFAULT,
   parameter logic [7:0]          NAK_BYTE       = NAK_DEFAULT,
   parameter int unsigned         TIMEOUT_CYCLES = 100_000_000
) (
   input logic                clk_i,
   input logic                rst_i,
   c2_channel_router_if.slave bus
);
   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   c2_state_t        state_q, state_d;
   logic [IDX_W-1:0] ch_q, ch_d;
   logic [IDX_W-1:0] rr_q;
   logic             nak_pend_q, nak_pend_d;
   logic             outstanding_q;
   logic [7:0]       tx_data_q;
   logic             tx_start_q;

   logic             cmd_hit;
   logic [IDX_W-1:0] cmd_idx;
   logic             nak_req, nak_push, ack_push, ctrl_busy;
   logic             tx_sel_hit;
   logic [IDX_W-1:0] tx_sel;
   logic [7:0]       push_data;
   logic             fifo_push, fifo_full, fifo_empty, pop, space;
   logic [7:0]       fifo_rdata;
   logic             wd_timeout;

   always_comb begin
      cmd_hit = 1'b0;
      cmd_idx = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!cmd_hit && bus.rx_data_i == CMD_CODES[8*i +: 8]) begin
            cmd_hit = 1'b1;
            cmd_idx = IDX_W'(i);
         end
      end
   end

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
   assign pop   = !fifo_empty && !outstanding_q;
   assign space = !fifo_full || pop;

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      nak_req  = 1'b0;
      ack_push = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.rx_ready_i) begin
               if (cmd_hit) begin
                  ch_d    = cmd_idx;
                  state_d = S_ACK;
               end else begin
                  nak_req = 1'b1;
               end
            end
         end
         S_ACK: begin
            if (space && !nak_pend_q) begin
               ack_push = 1'b1;
               state_d  = S_GRANT;
            end
         end
         S_GRANT: begin
            if (bus.ch_done_i[ch_q]) begin
               state_d = S_IDLE;
            end else if (wd_timeout) begin
               nak_req = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A NAK that finds no room is parked and goes out ahead of any later ACK.
   assign nak_push   = (nak_pend_q || nak_req) && space;
   assign nak_pend_d = (nak_pend_q && nak_req) || ((nak_pend_q || nak_req) && !space);
   assign ctrl_busy  = nak_pend_q || nak_req || (state_q == S_ACK);

   always_comb begin
      int unsigned idx;
      logic [IDX_W-1:0] cand;
      idx        = 0;
      cand       = '0;
      tx_sel_hit = 1'b0;
      tx_sel     = '0;
      if (space && !ctrl_busy) begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(rr_q) + k + 1;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = IDX_W'(idx);
            if (!tx_sel_hit && bus.ch_tx_valid_i[cand]) begin
               tx_sel_hit = 1'b1;
               tx_sel     = cand;
            end
         end
      end
   end

   always_comb begin
      push_data = bus.ch_tx_data_i[{tx_sel, 3'b000} +: 8];
      if (ack_push) push_data = ACK_BYTE;
      if (nak_push) push_data = NAK_BYTE;
   end

   assign fifo_push = nak_push || ack_push || tx_sel_hit;

   c2_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .wdata_i (push_data),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         ch_q          <= '0;
         rr_q          <= '0;
         nak_pend_q    <= 1'b0;
         outstanding_q <= 1'b0;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         nak_pend_q <= nak_pend_d;
         tx_start_q <= pop;
         if (tx_sel_hit) rr_q <= tx_sel;
         if (pop) begin
            tx_data_q     <= fifo_rdata;
            outstanding_q <= 1'b1;
         end else if (bus.tx_done_i) begin
            outstanding_q <= 1'b0;
         end
      end
   end

`ifdef C2_ROUTER_TIMEOUT_EN
   logic [31:0] wd_q;
   logic        wd_clear;

   assign wd_clear = bus.rx_ready_i || (tx_sel_hit && tx_sel == ch_q);

   always_ff @(posedge clk_i) begin
      if (rst_i || state_q != S_GRANT || wd_clear) wd_q <= '0;
      else                                         wd_q <= wd_q + 32'd1;
   end

   assign wd_timeout = (state_q == S_GRANT) && (wd_q == 32'(TIMEOUT_CYCLES - 1));
`else
   assign wd_timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

   always_comb begin
      bus.ch_grant_o = '0;
      if (state_q == S_GRANT) bus.ch_grant_o[ch_q] = 1'b1;
   end

   always_comb begin
      bus.ch_tx_ready_o = '0;
      if (tx_sel_hit) bus.ch_tx_ready_o[tx_sel] = 1'b1;
   end

   assign bus.ch_rx_valid_o = bus.ch_grant_o & {NUM_CH{bus.rx_ready_i}};
   assign bus.ch_rx_data_o  = bus.rx_data_i;
   assign bus.tx_data_o     = tx_data_q;
   assign bus.tx_start_o    = tx_start_q;
   assign bus.soft_reset_o  = ack_push;
   assign bus.waiting_o     = (state_q == S_IDLE);
   assign bus.busy_o        = !fifo_empty || outstanding_q;
endmodule
